nibble_serial_subtractor: RTL and testbench

//  Multi-cycle 16-bit subtractor, the subtract-side companion to the 16-bit CLA adder datapath.

---
 rtl/nibble_serial_subtractor_if.sv | 24 ++
 rtl/nibble_serial_subtractor.sv | 115 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - request/result bundle for the digit-serial subtractor
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - digit-serial A-B-Bin subtractor, optional saturation via SUB_SAT_EN
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  nibble_serial_subtractor_if.slave bus
);
  // DIGIT must be at least 2 so the borrow into the MSB bit can be separated from the slice borrow
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NSLICE-1:0][DIGIT-1:0] a_q;
  logic [NSLICE-1:0][DIGIT-1:0] b_q;
  logic [NSLICE-1:0][DIGIT-1:0] diff_q;
  logic [IDXW-1:0]              idx;
  logic                         brw;
  logic                         bout_q;
  logic                         ovf_q;

  logic                         accept;
  logic                         last;
  logic [DIGIT-1:0]             a_sl;
  logic [DIGIT-1:0]             b_sl;
  logic [DIGIT:0]               sl_full;
  logic [DIGIT-1:0]             sl_low;
  logic                         brw_into_msb;
  logic                         ovf_now;

  assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (idx == IDXW'(NSLICE - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start is only honoured outside CALC, so re-pulses while busy are ignored
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.start) state_next = S_CALC;
      S_CALC: if (last) state_next = S_DONE;
      S_DONE: state_next = bus.start ? S_CALC : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Current slice difference; the low DIGIT-1 bits are redone alone to expose the borrow into the MSB
  always_comb begin
    a_sl         = a_q[idx];
    b_sl         = b_q[idx];
    sl_full      = {1'b0, a_sl} - {1'b0, b_sl} - {{DIGIT{1'b0}}, brw};
    sl_low       = {1'b0, a_sl[DIGIT-2:0]} - {1'b0, b_sl[DIGIT-2:0]} - {{(DIGIT-1){1'b0}}, brw};
    brw_into_msb = sl_low[DIGIT-1];
    ovf_now      = brw_into_msb ^ sl_full[DIGIT];
  end

  // Operand capture on accept, then one slice per clock with the borrow rippling forward
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      brw    <= bus.bin;
      diff_q <= '0;
      idx    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == S_CALC) begin
      diff_q[idx] <= sl_full[DIGIT-1:0];
      brw         <= sl_full[DIGIT];
      if (last) begin
        bout_q <= sl_full[DIGIT];
        ovf_q  <= ovf_now;
`ifdef SUB_SAT_EN
        // Clamp toward the sign of the minuend: positive overflow -> max, negative -> min
        if (ovf_now) begin
          diff_q <= {a_q[NSLICE-1][DIGIT-1], {(WIDTH-1){~a_q[NSLICE-1][DIGIT-1]}}};
        end
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.busy = (state == S_CALC);
  assign bus.done = (state == S_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed vector bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff_wrap;
    logic [15:0] diff_sat;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pick_diff(input vec_t v);
`ifdef SUB_SAT_EN
    return v.diff_sat;
`else
    return v.diff_wrap;
`endif
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
  endtask

  // Four busy cycles after the accepting edge; start is dropped at the first of them
  task automatic busy_phase(input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      check($sformatf("%s busy%0d", tag, k), 32'(bus.busy), 32'd1);
      check($sformatf("%s nodone%0d", tag, k), 32'(bus.done), 32'd0);
    end
  endtask

  task automatic expect_done(input string tag, input logic [15:0] d, input logic bo, input logic ov);
    @(negedge clk);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy_low"}, 32'(bus.busy), 32'd0);
    check({tag, " diff"}, 32'(bus.diff), 32'(d));
    check({tag, " bout"}, 32'(bus.bout), 32'(bo));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(ov));
  endtask

  initial begin
    bit seen_done;

    vecs[0] = '{a:16'h1234, b:16'h0234, bin:1'b0, diff_wrap:16'h1000, diff_sat:16'h1000, bout:1'b0, ovf:1'b0};
    vecs[1] = '{a:16'h0000, b:16'h0001, bin:1'b0, diff_wrap:16'hFFFF, diff_sat:16'hFFFF, bout:1'b1, ovf:1'b0};
    vecs[2] = '{a:16'h8000, b:16'h0001, bin:1'b0, diff_wrap:16'h7FFF, diff_sat:16'h8000, bout:1'b0, ovf:1'b1};
    vecs[3] = '{a:16'h7FFF, b:16'hFFFF, bin:1'b0, diff_wrap:16'h8000, diff_sat:16'h7FFF, bout:1'b1, ovf:1'b1};
    vecs[4] = '{a:16'h0000, b:16'h8000, bin:1'b0, diff_wrap:16'h8000, diff_sat:16'h7FFF, bout:1'b1, ovf:1'b1};
    vecs[5] = '{a:16'hFFFF, b:16'hFFFF, bin:1'b1, diff_wrap:16'hFFFF, diff_sat:16'hFFFF, bout:1'b1, ovf:1'b0};
    vecs[6] = '{a:16'h1000, b:16'h0001, bin:1'b0, diff_wrap:16'h0FFF, diff_sat:16'h0FFF, bout:1'b0, ovf:1'b0};
    vecs[7] = '{a:16'h8000, b:16'h8000, bin:1'b0, diff_wrap:16'h0000, diff_sat:16'h0000, bout:1'b0, ovf:1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset diff", 32'(bus.diff), 32'd0);
    check("reset bout", 32'(bus.bout), 32'd0);
    check("reset ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle done", 32'(bus.done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin);
      busy_phase($sformatf("vec%0d", i));
      expect_done($sformatf("vec%0d", i), pick_diff(vecs[i]), vecs[i].bout, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d pulse_end", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d idle", i), 32'(bus.busy), 32'd0);
    end

    // Back-to-back: a new start in the done cycle is accepted immediately
    issue(16'h0005, 16'h0005, 1'b1);
    busy_phase("b2b_first");
    expect_done("b2b_first", 16'hFFFF, 1'b1, 1'b0);
    issue(16'h0010, 16'h0001, 1'b0);
    busy_phase("b2b_second");
    expect_done("b2b_second", 16'h000F, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b pulse_end", 32'(bus.done), 32'd0);

    // start re-pulsed at t+2 with different operands must not disturb the running operation
    issue(16'h1234, 16'h0234, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("repulse busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    issue(16'hFFFF, 16'h0000, 1'b1);
    check("repulse busy2", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check("repulse busy3", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("repulse busy4", 32'(bus.busy), 32'd1);
    expect_done("repulse", 16'h1000, 1'b0, 1'b0);
    @(negedge clk);

    // Reset at t+3 aborts the operation and no done pulse follows
    issue(16'h1234, 16'h0001, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort diff", 32'(bus.diff), 32'd0);
    check("abort bout", 32'(bus.bout), 32'd0);
    check("abort ovf", 32'(bus.ovf), 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("abort no_done", 32'(seen_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
